// File: rtl/jtag_scan_master.sv
// JTAG scan master: one IR + DR scan per command toward a single target TAP, TCK derived from clk.
// Optional IR cache that skips a repeated IR scan is built when JTAG_SCAN_MASTER_IR_CACHE_EN is defined.
module jtag_scan_master #(
    parameter int TCK_DIV  = 4,
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int PW   = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;
    localparam int MAXW = (IR_WIDTH > DR_WIDTH) ? IR_WIDTH : DR_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(TCK_DIV - 1);

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_e;

    typedef enum logic [2:0] {
        S_INIT, S_INIT_END, S_IDLE, S_SCAN, S_SCAN_END
    } ctl_e;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TAP_TLR:    return m ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    return m ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: return m ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: return m ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  return m ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: return m ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: return m ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: return m ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: return m ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: return m ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: return m ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  return m ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: return m ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: return m ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: return m ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: return m ? TAP_SEL_DR : TAP_RTI;
            default:    return TAP_TLR;
        endcase
    endfunction

    ctl_e                ctl_q, ctl_d;
    tap_e                tap_q, tap_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic [2:0]          rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                ir_done_q, ir_done_d;
    logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
    logic [DR_WIDTH-1:0] dr_sh_q, dr_sh_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic                accept;
    logic                skip_ir;

    assign accept = (ctl_q == S_IDLE) && cmd_valid;

`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
    logic [IR_WIDTH-1:0] cache_q;
    logic [IR_WIDTH-1:0] ir_cmd_q;
    logic                cache_vld_q;

    // The cache only learns an IR once its scan has completed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_q     <= '0;
            ir_cmd_q    <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            if (accept) ir_cmd_q <= cmd_ir;
            if (ctl_q == S_SCAN_END) begin
                cache_q     <= ir_cmd_q;
                cache_vld_q <= 1'b1;
            end
        end
    end

    assign skip_ir = cache_vld_q && (cmd_ir == cache_q);
`else
    assign skip_ir = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        ctl_d       = ctl_q;
        tap_d       = tap_q;
        phase_d     = phase_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rst_cnt_d   = rst_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        ir_done_d   = ir_done_q;
        ir_sh_d     = ir_sh_q;
        dr_sh_d     = dr_sh_q;
        rsp_valid_d = 1'b0;
        rsp_ir_d    = rsp_ir_q;
        rsp_dr_d    = rsp_dr_q;

        case (ctl_q)
            S_INIT, S_SCAN: begin
                if (phase_q != PHASE_LAST) begin
                    phase_d = phase_q + PW'(1);
                end else begin
                    phase_d = '0;
                    tck_d   = ~tck_q;
                    if (!tck_q) begin
                        // Rising TCK: the TAP advances on the TMS it sees and TDO is sampled.
                        tap_d = tap_next(tap_q, tms_q);
                        if (ctl_q == S_INIT) rst_cnt_d = rst_cnt_q + 3'd1;
                        if (tap_q == TAP_SH_IR) begin
                            ir_sh_d = ir_sh_q >> 1;
                            ir_sh_d[IR_WIDTH-1] = tdo;
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end else if (tap_q == TAP_SH_DR) begin
                            dr_sh_d = dr_sh_q >> 1;
                            dr_sh_d[DR_WIDTH-1] = tdo;
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end else begin
                            bit_cnt_d = '0;
                        end
                        if (tap_q == TAP_UPD_IR) ir_done_d = 1'b1;
                    end else begin
                        // Falling TCK: present TMS/TDI for the next rising edge.
                        tms_d = 1'b0;
                        tdi_d = 1'b0;
                        case (tap_q)
                            TAP_TLR:    tms_d = (rst_cnt_q < 3'd5);
                            TAP_RTI:    ctl_d = (ctl_q == S_INIT) ? S_INIT_END : S_SCAN_END;
                            TAP_SEL_DR: tms_d = ~ir_done_q;
                            TAP_SH_IR: begin
                                tms_d = (bit_cnt_q == CW'(IR_WIDTH - 1));
                                tdi_d = ir_sh_q[0];
                            end
                            TAP_SH_DR: begin
                                tms_d = (bit_cnt_q == CW'(DR_WIDTH - 1));
                                tdi_d = dr_sh_q[0];
                            end
                            TAP_EX1_IR, TAP_UPD_IR, TAP_EX1_DR: tms_d = 1'b1;
                            default:    tms_d = 1'b0;
                        endcase
                    end
                end
            end
            S_INIT_END: ctl_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    ctl_d     = S_SCAN;
                    tms_d     = 1'b1;
                    ir_done_d = skip_ir;
                    dr_sh_d   = cmd_dr;
                    // A skipped IR scan leaves the last captured IR in ir_sh_q for the response.
                    if (!skip_ir) ir_sh_d = cmd_ir;
                end
            end
            S_SCAN_END: begin
                ctl_d       = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_ir_d    = ir_sh_q;
                rsp_dr_d    = dr_sh_q;
            end
            default: ctl_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q       <= S_INIT;
            tap_q       <= TAP_TLR;
            phase_q     <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rst_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            ir_done_q   <= 1'b0;
            ir_sh_q     <= '0;
            dr_sh_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ir_q    <= '0;
            rsp_dr_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            ctl_q       <= ctl_d;
            tap_q       <= tap_d;
            phase_q     <= phase_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rst_cnt_q   <= rst_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            ir_done_q   <= ir_done_d;
            ir_sh_q     <= ir_sh_d;
            dr_sh_q     <= dr_sh_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ir_q    <= rsp_ir_d;
            rsp_dr_q    <= rsp_dr_d;
        end
    end

    assign cmd_ready = (ctl_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_ir    = rsp_ir_q;
    assign rsp_dr    = rsp_dr_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Self-checking bench for jtag_scan_master: records TMS/TDI/TDO at every TCK rise and compares
// against a sequence model of the scan; honours JTAG_SCAN_MASTER_IR_CACHE_EN.
module tb_jtag_scan_master;

    localparam int TCK_DIV = 4;
    localparam int IRW     = 2;
    localparam int DRW     = 38;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_dr;
    logic           rsp_valid;
    logic [IRW-1:0] rsp_ir;
    logic [DRW-1:0] rsp_dr;
    logic           tck;
    logic           tms;
    logic           tdi;
    logic           tdo;

    int   vectors = 0;
    int   miscompares = 0;

    // 0: tdo tied to tdi, 1: held high, 2: held low, 3: random bit per TCK period
    int   tdo_mode = 2;
    logic tdo_r = 1'b0;
    assign tdo = (tdo_mode == 0) ? tdi : tdo_r;

    jtag_scan_master #(.TCK_DIV(TCK_DIV), .IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir   (cmd_ir),
        .cmd_dr   (cmd_dr),
        .rsp_valid(rsp_valid),
        .rsp_ir   (rsp_ir),
        .rsp_dr   (rsp_dr),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin monitor: what a target TAP would see on each TCK rise.
    bit   rise_tms[$];
    bit   rise_tdi[$];
    bit   rise_tdo[$];
    int   rsp_pulses = 0;
    int   glitch = 0;
    logic tck_prev = 1'b0;
    logic tms_prev = 1'b1;
    logic tdi_prev = 1'b0;

    always @(negedge clk) begin
        if (tck === 1'b1 && tck_prev === 1'b0) begin
            rise_tms.push_back(tms);
            rise_tdi.push_back(tdi);
            rise_tdo.push_back(tdo);
        end
        if (tck === 1'b1 && tck_prev === 1'b1 && (tms !== tms_prev || tdi !== tdi_prev))
            glitch++;
        if (tck === 1'b0 && tck_prev === 1'b1 && tdo_mode == 3)
            tdo_r = 1'($urandom_range(0, 1));
        if (rsp_valid === 1'b1) rsp_pulses++;
        tck_prev = tck;
        tms_prev = tms;
        tdi_prev = tdi;
    end

    // Reference model state.
    bit             exp_tms[$];
    bit             exp_tdi[$];
    int             dr_pos;
    bit             m_cache_vld = 0;
    logic [IRW-1:0] m_cache = '0;
    logic [IRW-1:0] m_ir_capt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_step(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
    endfunction

    function automatic void build_expect(input bit skip, input logic [IRW-1:0] ir,
                                         input logic [DRW-1:0] dr);
        exp_tms.delete();
        exp_tdi.delete();
        if (!skip) begin
            push_step(1, 0); push_step(1, 0); push_step(0, 0); push_step(0, 0);
            for (int i = 0; i < IRW; i++) push_step(i == IRW - 1, ir[i]);
            push_step(1, 0); push_step(1, 0); push_step(0, 0); push_step(0, 0);
        end else begin
            push_step(1, 0); push_step(0, 0); push_step(0, 0);
        end
        dr_pos = exp_tms.size();
        for (int i = 0; i < DRW; i++) push_step(i == DRW - 1, dr[i]);
        push_step(1, 0); push_step(0, 0);
    endfunction

    function automatic bit model_skip(input logic [IRW-1:0] ir);
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
        return m_cache_vld && (ir == m_cache);
`else
        return (ir !== ir);
`endif
    endfunction

    function automatic int seq_errors(input bit is_tms);
        int n = 0;
        int len = (rise_tms.size() < exp_tms.size()) ? rise_tms.size() : exp_tms.size();
        for (int i = 0; i < len; i++)
            if (is_tms ? (rise_tms[i] != exp_tms[i]) : (rise_tdi[i] != exp_tdi[i])) n++;
        return n;
    endfunction

    function automatic void clear_mon();
        rise_tms.delete();
        rise_tdi.delete();
        rise_tdo.delete();
        glitch = 0;
    endfunction

    // Release reset and check the 5x TMS=1, 1x TMS=0 walk into Run-Test/Idle.
    task automatic run_init();
        int cycles = 0;
        int errs = 0;
        @(negedge clk);
        clear_mon();
        reset = 1'b0;
        while (cmd_ready !== 1'b1 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        #1;
        check("init_latency", cycles, 2 * TCK_DIV * 6 + 1);
        check("init_tck_cycles", rise_tms.size(), 6);
        for (int i = 0; i < rise_tms.size(); i++)
            if (rise_tms[i] != (i < 5) || rise_tdi[i] != 1'b0) errs++;
        check("init_tms_seq", errs, 0);
        check("init_tck_idle", tck, 1'b0);
        check("init_tms_idle", tms, 1'b0);
        check("init_rsp_quiet", rsp_pulses, 0);
    endtask

    task automatic do_scan(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                           input int mode, input bit poke);
        bit             skip;
        int             cycles = 0;
        int             base;
        logic [IRW-1:0] exp_ir;
        logic [DRW-1:0] exp_dr;
        skip = model_skip(ir);
        build_expect(skip, ir, dr);
        tdo_mode = mode;
        tdo_r = (mode == 1);
        @(negedge clk);
        #1;
        clear_mon();
        base = rsp_pulses;
        check("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_ir = ir;
        cmd_dr = dr;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_ir = ~ir;
        cmd_dr = ~dr;
        check("ready_drop", cmd_ready, 1'b0);
        while (rsp_valid !== 1'b1 && cycles < 2000) begin
            if (poke && cycles == 100) cmd_valid = 1'b1;
            if (poke && cycles == 104) cmd_valid = 1'b0;
            @(negedge clk);
            cycles++;
        end
        #1;
        check("scan_latency", cycles, 2 * TCK_DIV * exp_tms.size() + 1);
        check("scan_tck_cycles", rise_tms.size(), exp_tms.size());
        check("scan_tms_seq", seq_errors(1), 0);
        check("scan_tdi_seq", seq_errors(0), 0);
        exp_ir = skip ? m_ir_capt : '0;
        exp_dr = '0;
        if (!skip && rise_tdo.size() >= 4 + IRW)
            for (int i = 0; i < IRW; i++) exp_ir[i] = rise_tdo[4 + i];
        if (rise_tdo.size() >= dr_pos + DRW)
            for (int i = 0; i < DRW; i++) exp_dr[i] = rise_tdo[dr_pos + i];
        check("rsp_ir", rsp_ir, exp_ir);
        check("rsp_dr", rsp_dr, exp_dr);
        check("ready_with_rsp", cmd_ready, 1'b1);
        @(negedge clk);
        #1;
        check("rsp_one_pulse", rsp_valid, 1'b0);
        check("rsp_count", rsp_pulses - base, 1);
        check("rsp_dr_held", rsp_dr, exp_dr);
        check("pins_stable_tck_high", glitch, 0);
        check("idle_pins", {tck, tms, tdi}, 3'b000);
        if (!skip) m_ir_capt = exp_ir;
        m_cache = ir;
        m_cache_vld = 1;
    endtask

    // Abort a scan with reset on its 20th Shift-DR rising edge.
    task automatic abort_scan(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
        int cycles = 0;
        int base;
        build_expect(model_skip(ir), ir, dr);
        tdo_mode = 3;
        @(negedge clk);
        #1;
        clear_mon();
        base = rsp_pulses;
        cmd_valid = 1'b1;
        cmd_ir = ir;
        cmd_dr = dr;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (rise_tms.size() < dr_pos + 20 && cycles < 2000) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("abort_edge_reached", rise_tms.size(), dr_pos + 20);
        reset = 1'b1;
        #1;
        check("abort_tck", tck, 1'b0);
        check("abort_tms", tms, 1'b1);
        check("abort_tdi", tdi, 1'b0);
        check("abort_ready", cmd_ready, 1'b0);
        check("abort_rsp_regs", {rsp_valid, rsp_ir, rsp_dr}, '0);
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_rsp", rsp_pulses - base, 0);
        m_cache_vld = 0;
        m_ir_capt = '0;
        rsp_pulses = 0;
        run_init();
    endtask

    initial begin
        logic [IRW-1:0] r_ir;
        logic [DRW-1:0] r_dr;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir = '0;
        cmd_dr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pins", {tck, tms, tdi}, 3'b010);
        check("reset_ready", cmd_ready, 1'b0);
        check("reset_rsp", {rsp_valid, rsp_ir, rsp_dr}, '0);
        run_init();

        do_scan(2'b01, 38'h2A_5555_5555, 0, 0);
        check("loop_ir", rsp_ir, 2'b01);
        check("loop_dr", rsp_dr, 38'h2A_5555_5555);

        do_scan(2'b00, 38'h12_3456_789A, 1, 0);
        check("ones_ir", rsp_ir, 2'b11);
        check("ones_dr", rsp_dr, {DRW{1'b1}});

        do_scan(2'b11, 38'h3F_0F0F_0F0F, 2, 0);
        check("zeros_ir", rsp_ir, 2'b00);
        check("zeros_dr", rsp_dr, '0);

        // Cache sequence: repeated IR, then a new IR.
        do_scan(2'b10, 38'(({$urandom(), $urandom()})), 3, 0);
        do_scan(2'b10, 38'(({$urandom(), $urandom()})), 3, 0);
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
        check("cache_hit_len", rise_tms.size(), DRW + 5);
`else
        check("no_cache_len", rise_tms.size(), IRW + DRW + 10);
`endif
        do_scan(2'b11, 38'(({$urandom(), $urandom()})), 3, 0);
        check("cache_miss_len", rise_tms.size(), IRW + DRW + 10);

        // cmd_valid pulsed mid-scan is ignored.
        r_ir = 2'b01;
        r_dr = 38'(({$urandom(), $urandom()}));
        do_scan(r_ir, r_dr, 0, 1);
        check("poke_dr", rsp_dr, r_dr);

        for (int k = 0; k < 4; k++) begin
            r_ir = 2'($urandom_range(0, 3));
            r_dr = 38'(({$urandom(), $urandom()}));
            do_scan(r_ir, r_dr, (k == 1) ? 0 : 3, 0);
        end

        abort_scan(r_ir ^ 2'b01, 38'(({$urandom(), $urandom()})));
        do_scan(r_ir ^ 2'b01, 38'(({$urandom(), $urandom()})), 3, 0);
        check("post_reset_full_len", rise_tms.size(), IRW + DRW + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 4, clk cycles per TCK half-period (minimum 2).
REQ-002 SHALL have parameter IR_WIDTH, default 2, instruction register scan length.
REQ-003 SHALL have parameter DR_WIDTH, default 38, data register scan length.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  scan command offered.
REQ-007 SHALL have port cmd_ready  output  1  block idle in Run-Test/Idle; command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_ir  input  IR_WIDTH  instruction to shift.
REQ-009 SHALL have port cmd_dr  input  DR_WIDTH  data to shift.
REQ-010 SHALL have port rsp_valid  output  1  one-clk pulse; scan complete.
REQ-011 SHALL have port rsp_ir  output  IR_WIDTH  TDO captured during IR shift.
REQ-012 SHALL have port rsp_dr  output  DR_WIDTH  TDO captured during DR shift.
REQ-013 SHALL have ports tck, tms, tdi  output  1 each, and tdo  input  1; JTAG pins toward the target debug TAP.

Function
REQ-014 SHALL generate tck from a phase counter: low TCK_DIV clk cycles, high TCK_DIV clk cycles; tck SHALL stay low while idle.
REQ-015 SHALL update tms/tdi only on tck falling edges (or before the first rising edge) and SHALL sample tdo on tck rising edges.
REQ-016 SHALL track TAP states Test-Logic-Reset, RTI, Select-DR, Select-IR, Capture-IR, Shift-IR, Exit1-IR, Update-IR, Capture-DR, Shift-DR, Exit1-DR, Update-DR per IEEE 1149.1.
REQ-017 On accept SHALL latch cmd_ir/cmd_dr, drop cmd_ready the next clk, and drive TMS per rising edge: 1,1,0,0; IR_WIDTH shift edges (TMS 0, last 1); 1,1,0,0; DR_WIDTH shift edges (TMS 0, last 1); 1,0 -- total IR_WIDTH+DR_WIDTH+10 TCK cycles (50 at defaults), ending in RTI.
REQ-018 SHALL shift tdi LSB first; tdi SHALL be 0 outside Shift states.
REQ-019 SHALL shift sampled tdo into the MSB of the capture register, shifting right, so bit 0 holds the first captured bit.
REQ-020 SHALL pulse rsp_valid for one clk, one clk after the final tck falling edge, with rsp_ir/rsp_dr valid that cycle and held until the next rsp_valid; cmd_ready SHALL rise in the same cycle.
REQ-021 SHALL ignore cmd_valid while cmd_ready is low; no command queueing.
REQ-022 rsp_valid has no backpressure; the consumer SHALL take it the cycle it is high.

Reset
REQ-023 While reset is high SHALL force tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_ir=0, rsp_dr=0, phase counter 0.
REQ-024 After reset deasserts SHALL run 5 TCK cycles with TMS=1 then 1 with TMS=0 (Test-Logic-Reset then RTI) and assert cmd_ready on the clk following that final falling edge.
REQ-025 Reset mid-scan SHALL abort immediately; no rsp_valid for the aborted command; REQ-024 sequence restarts.

Configuration
REQ-026 Macro JTAG_SCAN_MASTER_IR_CACHE_EN defined: SHALL store the last completed IR value (invalidated by reset); a command whose cmd_ir equals it SHALL skip the IR scan (TMS 1,0,0; DR shift; 1,0 -- DR_WIDTH+5 TCK cycles, 43 at defaults), with rsp_ir equal to the previously captured value.
REQ-027 Macro undefined: every command SHALL perform the full IR+DR sequence of REQ-017, and no cache storage SHALL exist.

Verification
REQ-028 Release reset -> tms 1,1,1,1,1,0 over 6 TCK periods of 8 clk each; cmd_ready high afterwards; tck low when idle.
REQ-029 tdo tied to tdi; cmd_ir=2'b01, cmd_dr=38'h2A_5555_5555 -> rsp_ir=2'b01, rsp_dr=38'h2A_5555_5555, 50 TCK cycles, TMS pattern exactly per REQ-017.
REQ-030 tdo held 1 -> rsp_ir=2'b11, rsp_dr all ones; tdo held 0 -> all zeros.
REQ-031 Macro defined: two commands both with cmd_ir=2'b10 -> 50 then 43 TCK cycles; third command with cmd_ir=2'b11 -> 50; macro undefined -> 50 each.
REQ-032 Assert reset on the 20th Shift-DR edge -> tck=0, tms=1 immediately, no rsp_valid, cmd_ready returns after 6 TCK periods.
REQ-033 Pulse cmd_valid mid-scan -> ignored; rsp_valid fires exactly once, with the original data.
